// File: rtl/snake_pkg.sv
// Shared screen geometry, field widths and arbiter FSM encoding for the
// snake game's framebuffer drawing path.
package snake_pkg;

  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;

  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 9;
  localparam int DIM_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rect_fill_engine.sv
// Streams one latched rectangle in raster order, one pixel per clock, with
// off-screen pixels suppressed; start clears the counters, last flags the final pixel.
module rect_fill_engine
  import snake_pkg::*;
#(
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               run,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [DIM_W-1:0]   w,
  input  logic [DIM_W-1:0]   h,
  input  logic [COLOR_W-1:0] color,
  output logic               last,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_write
);

  localparam logic [X_W:0]       X_LIM   = XSCREEN[X_W:0];
  localparam logic [Y_W:0]       Y_LIM   = YSCREEN[Y_W:0];
  localparam logic [DIM_W-1:0]   DIM_ONE = 1;

  logic [DIM_W-1:0]   px_q, px_d, py_q, py_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_color_q, vga_color_d;
  logic               vga_write_q, vga_write_d;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;

  // One extra bit on each sum so a rectangle hanging off the right or
  // bottom edge is clipped instead of wrapping to column/row 0.
  assign x_sum = {1'b0, x0} + {{(X_W + 1 - DIM_W){1'b0}}, px_q};
  assign y_sum = {1'b0, y0} + {{(Y_W + 1 - DIM_W){1'b0}}, py_q};
  assign last  = run && (px_q == w - DIM_ONE) && (py_q == h - DIM_ONE);

  always_comb begin
    px_d        = px_q;
    py_d        = py_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_write_d = 1'b0;
    if (start) begin
      px_d = '0;
      py_d = '0;
    end else if (run) begin
      vga_x_d     = x_sum[X_W-1:0];
      vga_y_d     = y_sum[Y_W-1:0];
      vga_color_d = color;
      vga_write_d = (x_sum < X_LIM) && (y_sum < Y_LIM);
      if (px_q == w - DIM_ONE) begin
        px_d = '0;
        py_d = py_q + DIM_ONE;
      end else begin
        px_d = px_q + DIM_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      px_q        <= '0;
      py_q        <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
    end
  end

  assign vga_x     = vga_x_q;
  assign vga_y     = vga_y_q;
  assign vga_color = vga_color_q;
  assign vga_write = vga_write_q;

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates filled-rectangle commands from several clients onto the single
// framebuffer write port. Define ARB_ROUND_ROBIN_EN for rotating priority.
module pixel_write_arbiter
  import snake_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [X_W*NUM_REQ-1:0]     req_x,
  input  logic [Y_W*NUM_REQ-1:0]     req_y,
  input  logic [DIM_W*NUM_REQ-1:0]   req_w,
  input  logic [DIM_W*NUM_REQ-1:0]   req_h,
  input  logic [COLOR_W*NUM_REQ-1:0] req_color,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [X_W-1:0]             VGA_x,
  output logic [Y_W-1:0]             VGA_y,
  output logic [COLOR_W-1:0]         VGA_color,
  output logic                       VGA_write
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [DIM_W-1:0]     w_q, w_d, h_q, h_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [IDX_W-1:0]     sel;
  logic                 found;
  logic                 start, run, last;
  int                   base_idx, scan_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d, winner_q, winner_d;
  assign base_idx = int'(ptr_q);
`else
  assign base_idx = 0;
`endif

  // Scan upward from the base index, wrapping, and take the first requester.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = base_idx + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && req[scan_idx[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    start   = 1'b0;
    run     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
    winner_d = winner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The cycle that carries the done pulse is a dead cycle so the owner
        // has time to drop its request before it is seen as a new command.
        if (found && (done_q == '0)) begin
          x_d     = req_x[sel*X_W +: X_W];
          y_d     = req_y[sel*Y_W +: Y_W];
          w_d     = req_w[sel*DIM_W +: DIM_W];
          h_d     = req_h[sel*DIM_W +: DIM_W];
          color_d = req_color[sel*COLOR_W +: COLOR_W];
          grant_d = NUM_REQ'(1) << sel;
          start   = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          winner_d = sel;
`endif
          if ((req_w[sel*DIM_W +: DIM_W] == '0) || (req_h[sel*DIM_W +: DIM_W] == '0))
            state_d = ST_DONE;
          else
            state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        run = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= '0;
      winner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
`endif
    end
  end

  rect_fill_engine #(
    .XSCREEN(XSCREEN),
    .YSCREEN(YSCREEN)
  ) u_fill (
    .clk      (Clock),
    .resetn   (Resetn),
    .start    (start),
    .run      (run),
    .x0       (x_q),
    .y0       (y_q),
    .w        (w_q),
    .h        (h_q),
    .color    (color_q),
    .last     (last),
    .vga_x    (VGA_x),
    .vga_y    (VGA_y),
    .vga_color(VGA_color),
    .vga_write(VGA_write)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single 160x120 framebuffer pixel-write port (VGA_x, VGA_y, VGA_color, VGA_write) between several drawing clients, such as the snake body drawer, the food placer and the screen clear. Each client posts a filled-rectangle command. The block arbitrates between clients, streams the granted rectangle one pixel per clock, clips pixels that fall off-screen, and returns a one-cycle done pulse to the owner. It sits between the game-logic FSMs and the VGA adapter's write port.

## Interface
- NUM_REQ, 3, number of requesting clients (2..8)
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels
- Clock  in  1  system clock (CLOCK_50 domain)
- Resetn  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-client level request
- req_x  in  8*NUM_REQ  rectangle left x per client; client i uses bits [8i+7:8i]
- req_y  in  7*NUM_REQ  rectangle top y per client
- req_w  in  4*NUM_REQ  rectangle width, 0..15
- req_h  in  4*NUM_REQ  rectangle height, 0..15
- req_color  in  9*NUM_REQ  RGB 3:3:3 fill colour
- grant  out  NUM_REQ  one-hot; high while that client's command is being serviced
- done  out  NUM_REQ  one-cycle pulse to the owner when its command completes
- busy  out  1  high in any state other than IDLE
- VGA_x  out  8  pixel x
- VGA_y  out  7  pixel y
- VGA_color  out  9  pixel colour
- VGA_write  out  1  pixel write strobe

## Operation
- FSM states are IDLE, FILL and DONE.
- IDLE:
  - If any req is high, select a winner, latch its x/y/w/h/colour, set grant to the winner's one-hot value, clear px/py, and go to FILL.
  - If the latched w==0 or h==0, go directly to DONE instead; no pixels are written.
- FILL, once per cycle:
  - Register VGA_x = x0+px, VGA_y = y0+py and VGA_color = colour.
  - Raster order: px advances fastest; at px==w-1, px returns to 0 and py increments.
  - After pixel (w-1, h-1), go to DONE.
- Clipping: compute sums at 9 bits for x and 8 bits for y. If x0+px >= XSCREEN or y0+py >= YSCREEN:
  - VGA_write=0 for that cycle;
  - the pixel still consumes its cycle;
  - there is no wrap-around.
- DONE:
  - Register VGA_write=0, done[winner]=1 and grant=0.
  - Update the arbitration pointer (see Configuration).
  - Go to IDLE.
- Commands are latched, so the client may change its command fields once grant is high.
- A client must drop req in the cycle done is high, unless it intends to post another command. A req still high in the following IDLE cycle is treated as a new command.
- A req that falls while its command is being serviced does not abort the command.
- Requests arriving during FILL/DONE wait; none are lost while req stays high.
- Simultaneous requests: exactly one grant is issued; the rest wait.

## Timing
- Reset values: grant=0, done=0, busy=0, VGA_write=0, VGA_x=0, VGA_y=0, VGA_color=0, state=IDLE, pointer=0.
- Reset mid-command: all of the above apply at the next edge. The command is discarded and no done pulse is issued.
- Edge E0: IDLE sees req and grant rises.
- Edges E1..E(w*h): pixel k-1 is visible on the VGA outputs after edge Ek.
- Edge E(w*h+1): VGA_write falls and done pulses high.
- Edge E(w*h+2): done falls and the state is IDLE.
  - The earliest next grant is edge E(w*h+3).
- Command cost is w*h+3 cycles; there are at least 2 idle write cycles between commands.
- Zero-size command: grant at E0, done high after E1, grant low after E1, no VGA_write.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - In DONE, pointer = (winner+1) mod NUM_REQ.
  - No client waits more than NUM_REQ-1 commands.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins.
  - The pointer register is not built.
  - Starvation of high indices is permitted.

## Structure
- Shared package (snake_pkg) holds:
  - XSCREEN/YSCREEN defaults;
  - coordinate widths (8/7), colour width (9) and dimension width (4);
  - the FSM state encoding.
- Sub-module rect_fill_engine contains px/py counters, clipping and the registered VGA outputs, with start/last handshake.
- The arbiter top contains the winner selection, command latch, grant/done logic and pointer.

## Test plan
- Single command: client 0 with x=10, y=20, w=4, h=4, colour 9'h1C0.
  - 16 writes, ordered (10,20),(11,20)..(13,23).
  - done[0] is high exactly once, 17 cycles after grant rose.
- Clipping: x=157, y=118, w=4, h=3.
  - 12 FILL cycles; writes only at x 157..159 and y 118..119 (6 writes).
  - No coordinate wraps to 0.
- Contention: req=3'b111, all w=h=1.
  - Round-robin build: grants in order 0,1,2, each 4 cycles apart.
  - Fixed-priority build: client 0 wins every arbitration while its req is held.
- Zero size: w=0, h=5 on client 2.
  - No VGA_write; done[2] pulses after one cycle of grant.
- Reset mid-fill: Resetn=0 on the 5th pixel of an 8x8 command.
  - All outputs are 0 at the next edge, with no done pulse.
  - After release, a new req is granted normally.
- Late req drop: client 1 holds req one cycle beyond done.
  - A second command is serviced with the fields present at that IDLE cycle.
